// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard.
//   - Forwarding-select encodings driven on srcN_fwd_sel.
//   - Bit layout of one in-flight entry {w_addr, is_load, w_en, valid},
//     stored as a flat vector so the address width can be parameterised.
package issue_scoreboard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  // Entry field offsets (LSB first).
  localparam int SB_VALID    = 0;
  localparam int SB_W_EN     = 1;
  localparam int SB_IS_LOAD  = 2;
  localparam int SB_ADDR_LSB = 3;

  // Default register address width (32 GPRs) and resulting entry width.
  localparam int SB_ADDR_W   = 5;
  localparam int SB_ENTRY_WD = SB_ADDR_LSB + SB_ADDR_W;

endpackage

// File: rtl/sb_lookup.sv
// Combinational hazard lookup for one source operand.
// Ports:
//   src_used_i, src_addr_i : the source operand being resolved
//   exe_e_i, mem_e_i, wb_e_i : the three in-flight entries (package layout)
//   ready_o : operand is obtainable this cycle
//   sel_o   : forwarding select (FWD_RF/EXE/MEM/WB)
module sb_lookup
  import issue_scoreboard_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W
) (
  input  logic                          src_used_i,
  input  logic [ADDR_W-1:0]             src_addr_i,
  input  logic [SB_ADDR_LSB+ADDR_W-1:0] exe_e_i,
  input  logic [SB_ADDR_LSB+ADDR_W-1:0] mem_e_i,
  input  logic [SB_ADDR_LSB+ADDR_W-1:0] wb_e_i,
  output logic                          ready_o,
  output logic [1:0]                    sel_o
);

  logic hit_exe, hit_mem, hit_wb;
  logic unused_wb_load;

  // An entry only hits when it is live and actually writes the register file.
  assign hit_exe = exe_e_i[SB_VALID] & exe_e_i[SB_W_EN] &
                   (exe_e_i[SB_ADDR_LSB +: ADDR_W] == src_addr_i);
  assign hit_mem = mem_e_i[SB_VALID] & mem_e_i[SB_W_EN] &
                   (mem_e_i[SB_ADDR_LSB +: ADDR_W] == src_addr_i);
  assign hit_wb  = wb_e_i[SB_VALID] & wb_e_i[SB_W_EN] &
                   (wb_e_i[SB_ADDR_LSB +: ADDR_W] == src_addr_i);

  // A load in WB has its data available, so the WB load flag is irrelevant.
  assign unused_wb_load = wb_e_i[SB_IS_LOAD];

  always_comb begin
    ready_o = 1'b1;
    sel_o   = FWD_RF;
    if (src_used_i && (src_addr_i != '0)) begin
      // Youngest producer wins, even when an older one would be ready.
      if (hit_exe) begin
        ready_o = ~exe_e_i[SB_IS_LOAD];
        sel_o   = FWD_EXE;
      end else if (hit_mem) begin
        // Load data only becomes forwardable once it reaches WB.
        ready_o = ~mem_e_i[SB_IS_LOAD];
        sel_o   = FWD_MEM;
      end else if (hit_wb) begin
        sel_o   = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue scoreboard for the decode/issue stage.
// Tracks the destination writes in flight in EXE, MEM and WB and resolves
// each of the two ID source operands to a ready flag and forwarding select.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   issue_*           : instruction leaving ID this cycle and its dest info
//   exe/mem/wb_fire   : stage-advance handshakes of the pipeline
//   flush             : kill every in-flight entry (beats all fires)
//   id_valid, srcN_*  : current ID instruction and its source operands
//   srcN_ready/fwd_sel: per-source lookup results (combinational)
//   issue_ready       : both sources obtainable
//   stall_cnt         : saturating count of cycles ID stalled on a hazard
//
// Handshake: each *_fire input is valid & allow_in of the next stage, i.e.
// a transfer completes on that clock edge. An entry moves forward only on the
// fire of its own stage; a stage whose entry leaves and receives nothing
// becomes invalid. Fires on empty stages are harmless.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_fire,
  input  logic              issue_rf_w_en,
  input  logic [ADDR_W-1:0] issue_rf_w_addr,
  input  logic              issue_is_load,
  input  logic              exe_fire,
  input  logic              mem_fire,
  input  logic              wb_fire,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              src1_used,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic              src2_used,
  input  logic [ADDR_W-1:0] src2_addr,
  output logic              src1_ready,
  output logic              src2_ready,
  output logic [1:0]        src1_fwd_sel,
  output logic [1:0]        src2_fwd_sel,
  output logic              issue_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int EW = SB_ADDR_LSB + ADDR_W;

  logic [EW-1:0]    exe_q, exe_d;
  logic [EW-1:0]    mem_q, mem_d;
  logic [EW-1:0]    wb_q,  wb_d;
  logic [EW-1:0]    issue_entry;
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    issue_entry                         = '0;
    issue_entry[SB_VALID]               = 1'b1;
    issue_entry[SB_W_EN]                = issue_rf_w_en;
    issue_entry[SB_IS_LOAD]             = issue_is_load;
    issue_entry[SB_ADDR_LSB +: ADDR_W]  = issue_rf_w_addr;
  end

  // All stages read pre-edge values, so a full simultaneous shift is lossless.
  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (flush) begin
      exe_d = '0;
      mem_d = '0;
      wb_d  = '0;
    end else begin
      if (mem_fire)      wb_d = mem_q;
      else if (wb_fire)  wb_d = '0;

      if (exe_fire)      mem_d = exe_q;
      else if (mem_fire) mem_d = '0;

      if (issue_fire)    exe_d = issue_entry;
      else if (exe_fire) exe_d = '0;
    end
  end

  // Saturating stall counter; flush deliberately leaves it alone.
  always_comb begin
    stall_d = stall_q;
    if (id_valid && !issue_ready && !(&stall_q)) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exe_q   <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      stall_q <= '0;
    end else begin
      exe_q   <= exe_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      stall_q <= stall_d;
    end
  end

  sb_lookup #(.ADDR_W(ADDR_W)) u_lookup_src1 (
    .src_used_i (src1_used),
    .src_addr_i (src1_addr),
    .exe_e_i    (exe_q),
    .mem_e_i    (mem_q),
    .wb_e_i     (wb_q),
    .ready_o    (src1_ready),
    .sel_o      (src1_fwd_sel)
  );

  sb_lookup #(.ADDR_W(ADDR_W)) u_lookup_src2 (
    .src_used_i (src2_used),
    .src_addr_i (src2_addr),
    .exe_e_i    (exe_q),
    .mem_e_i    (mem_q),
    .wb_e_i     (wb_q),
    .ready_o    (src2_ready),
    .sel_o      (src2_fwd_sel)
  );

  assign issue_ready = src1_ready & src2_ready;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard. Stimulus tasks push hand-computed
// expected outputs into exp_q; a negedge monitor pops and compares.
module tb_issue_scoreboard;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 32;
  localparam int W      = 1 + 2 + 1 + 2 + 1 + CNT_W;

  logic              clk;
  logic              reset;
  logic              issue_fire;
  logic              issue_rf_w_en;
  logic [ADDR_W-1:0] issue_rf_w_addr;
  logic              issue_is_load;
  logic              exe_fire;
  logic              mem_fire;
  logic              wb_fire;
  logic              flush;
  logic              id_valid;
  logic              src1_used;
  logic [ADDR_W-1:0] src1_addr;
  logic              src2_used;
  logic [ADDR_W-1:0] src2_addr;
  logic              src1_ready;
  logic              src2_ready;
  logic [1:0]        src1_fwd_sel;
  logic [1:0]        src2_fwd_sel;
  logic              issue_ready;
  logic [CNT_W-1:0]  stall_cnt;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           compared   = 0;
  int           mismatched = 0;

  issue_scoreboard #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .issue_fire      (issue_fire),
    .issue_rf_w_en   (issue_rf_w_en),
    .issue_rf_w_addr (issue_rf_w_addr),
    .issue_is_load   (issue_is_load),
    .exe_fire        (exe_fire),
    .mem_fire        (mem_fire),
    .wb_fire         (wb_fire),
    .flush           (flush),
    .id_valid        (id_valid),
    .src1_used       (src1_used),
    .src1_addr       (src1_addr),
    .src2_used       (src2_used),
    .src2_addr       (src2_addr),
    .src1_ready      (src1_ready),
    .src2_ready      (src2_ready),
    .src1_fwd_sel    (src1_fwd_sel),
    .src2_fwd_sel    (src2_fwd_sel),
    .issue_ready     (issue_ready),
    .stall_cnt       (stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    string        nm;
    got = {src1_ready, src1_fwd_sel, src2_ready, src2_fwd_sel, issue_ready, stall_cnt};
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL %s: got r1=%b s1=%0d r2=%b s2=%0d ir=%b cnt=%0d, exp r1=%b s1=%0d r2=%b s2=%0d ir=%b cnt=%0d",
                 nm, got[W-1], got[W-2:W-3], got[W-4], got[W-5:W-6], got[W-7], got[CNT_W-1:0],
                 exp[W-1], exp[W-2:W-3], exp[W-4], exp[W-5:W-6], exp[W-7], exp[CNT_W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Advance one clock; single-cycle pulses drop after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    issue_fire = 1'b0;
    exe_fire   = 1'b0;
    mem_fire   = 1'b0;
    wb_fire    = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] addr, input logic ld, input logic wen);
    issue_fire      = 1'b1;
    issue_rf_w_en   = wen;
    issue_rf_w_addr = addr;
    issue_is_load   = ld;
  endtask

  task automatic set_src(input logic u1, input logic [ADDR_W-1:0] a1,
                         input logic u2, input logic [ADDR_W-1:0] a2);
    src1_used = u1;
    src1_addr = a1;
    src2_used = u2;
    src2_addr = a2;
  endtask

  // Queue one expectation, then let the monitor sample it at the negedge.
  task automatic expect_out(input string nm, input logic r1, input logic [1:0] s1,
                            input logic r2, input logic [1:0] s2, input logic ir,
                            input logic [CNT_W-1:0] cnt);
    exp_q.push_back({r1, s1, r2, s2, ir, cnt});
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    issue_fire = 1'b0; issue_rf_w_en = 1'b0; issue_rf_w_addr = '0; issue_is_load = 1'b0;
    exe_fire = 1'b0; mem_fire = 1'b0; wb_fire = 1'b0; flush = 1'b0;
    id_valid = 1'b0;
    set_src(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    tick();
    reset = 1'b0;

    // Reset then idle
    set_src(1'b1, 5'd5, 1'b0, 5'd0);
    expect_out("reset_idle", 1, 0, 1, 0, 1, 0);

    // ALU producer r5 walking through the pipe
    issue(5'd5, 1'b0, 1'b1); tick();
    expect_out("alu_exe", 1, 1, 1, 0, 1, 0);
    exe_fire = 1'b1; tick();
    expect_out("alu_mem", 1, 2, 1, 0, 1, 0);
    mem_fire = 1'b1; tick();
    expect_out("alu_wb", 1, 3, 1, 0, 1, 0);
    wb_fire = 1'b1; tick();
    expect_out("alu_gone", 1, 0, 1, 0, 1, 0);

    // Load-use on r7 via src2
    set_src(1'b0, 5'd0, 1'b0, 5'd0);
    issue(5'd7, 1'b1, 1'b1); tick();
    set_src(1'b0, 5'd0, 1'b1, 5'd7);
    id_valid = 1'b1;
    expect_out("ld_exe_c0", 1, 0, 0, 1, 0, 0);
    tick();
    expect_out("ld_exe_c1", 1, 0, 0, 1, 0, 1);
    tick();
    tick();
    expect_out("ld_stall3", 1, 0, 0, 1, 0, 3);
    exe_fire = 1'b1; tick();
    expect_out("ld_mem", 1, 0, 0, 2, 0, 4);
    mem_fire = 1'b1; tick();
    expect_out("ld_wb", 1, 0, 1, 3, 1, 5);
    wb_fire = 1'b1; tick();
    expect_out("ld_gone", 1, 0, 1, 0, 1, 5);
    id_valid = 1'b0;

    // Youngest wins: ld r3 in MEM, add r3 in EXE
    issue(5'd3, 1'b1, 1'b1); tick();
    exe_fire = 1'b1; issue(5'd3, 1'b0, 1'b1); tick();
    set_src(1'b1, 5'd3, 1'b1, 5'd7);
    expect_out("young_alu", 1, 1, 1, 0, 1, 5);
    flush = 1'b1; tick();
    expect_out("young_flush", 1, 0, 1, 0, 1, 5);

    // Reverse: add r3 in MEM, ld r3 in EXE; stall then flush keeps counter
    issue(5'd3, 1'b0, 1'b1); tick();
    exe_fire = 1'b1; issue(5'd3, 1'b1, 1'b1); tick();
    id_valid = 1'b1;
    expect_out("young_load", 0, 1, 1, 0, 0, 5);
    flush = 1'b1; tick();
    id_valid = 1'b0;
    expect_out("flush_keeps_cnt", 1, 0, 1, 0, 1, 6);

    // r0 producer in MEM, non-writing r9 in EXE
    issue(5'd0, 1'b0, 1'b1); tick();
    set_src(1'b1, 5'd0, 1'b0, 5'd0);
    expect_out("r0_src", 1, 0, 1, 0, 1, 6);
    exe_fire = 1'b1; issue(5'd9, 1'b1, 1'b0); tick();
    set_src(1'b1, 5'd9, 1'b1, 5'd0);
    expect_out("wen0_nomatch", 1, 0, 1, 0, 1, 6);
    flush = 1'b1; tick();

    // Fill all three stages, then flush together with an issue
    issue(5'd10, 1'b0, 1'b1); tick();
    exe_fire = 1'b1; issue(5'd11, 1'b0, 1'b1); tick();
    mem_fire = 1'b1; exe_fire = 1'b1; issue(5'd12, 1'b0, 1'b1); tick();
    set_src(1'b1, 5'd10, 1'b1, 5'd11);
    expect_out("full_wb_mem", 1, 3, 1, 2, 1, 6);
    set_src(1'b1, 5'd12, 1'b1, 5'd11);
    flush = 1'b1; exe_fire = 1'b1; mem_fire = 1'b1; wb_fire = 1'b1;
    issue(5'd13, 1'b0, 1'b1); tick();
    expect_out("flush_exe_mem", 1, 0, 1, 0, 1, 6);
    set_src(1'b1, 5'd13, 1'b1, 5'd10);
    expect_out("flush_drops_issue", 1, 0, 1, 0, 1, 6);

    // Simultaneous shift of a full pipe
    issue(5'd20, 1'b0, 1'b1); tick();
    exe_fire = 1'b1; issue(5'd21, 1'b0, 1'b1); tick();
    mem_fire = 1'b1; exe_fire = 1'b1; issue(5'd22, 1'b0, 1'b1); tick();
    wb_fire = 1'b1; mem_fire = 1'b1; exe_fire = 1'b1; issue(5'd23, 1'b0, 1'b1); tick();
    set_src(1'b1, 5'd20, 1'b1, 5'd21);
    expect_out("shift_drop_wb", 1, 0, 1, 3, 1, 6);
    set_src(1'b1, 5'd22, 1'b1, 5'd23);
    expect_out("shift_mem_exe", 1, 2, 1, 1, 1, 6);

    // Anything still queued was never checked
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: got %0d left, exp 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
